// File: rtl/downsample_pkg.sv
// Shared constants, sum widths and phase encoding for the 2x2 box-filter decimator.
package downsample_pkg;

  localparam int DS_LENGTH = 16;
  localparam int DS_WIDTH  = 16;
  localparam int DS_HEIGHT = 16;

  localparam int DS_SUM_W = DS_LENGTH + 1;
  localparam int DS_TOT_W = DS_LENGTH + 2;

  // Phase is {row[0], col[0]} of the pixel being accepted.
  typedef enum logic [1:0] {
    PH_EVEN_ROW_EVEN_COL = 2'b00,
    PH_EVEN_ROW_ODD_COL  = 2'b01,
    PH_ODD_ROW_EVEN_COL  = 2'b10,
    PH_ODD_ROW_ODD_COL   = 2'b11
  } phase_e;

  function automatic int sum_w(input int l);
    return l + 1;
  endfunction

  function automatic int tot_w(input int l);
    return l + 2;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ds_line_buffer.sv
// Half-width line buffer holding even-row horizontal pair sums.
// Synchronous write, combinational read; contents are not reset.
module ds_line_buffer #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/downsample_2x2.sv
// Streaming 2x2 box-filter decimator: one averaged pixel per 2x2 input block.
// Define DOWNSAMPLE_ROUND_EN for round-half-up averaging; default is floor.
module downsample_2x2
  import downsample_pkg::*;
#(
  parameter int length = DS_LENGTH,
  parameter int WIDTH  = DS_WIDTH,
  parameter int HEIGHT = DS_HEIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [length-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [length-1:0] m_data,
  output logic              m_last
);

  localparam int SUM_W = sum_w(length);
  localparam int TOT_W = tot_w(length);
  localparam int CW    = cnt_w(WIDTH);
  localparam int RW    = cnt_w(HEIGHT);
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = cnt_w(DEPTH);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [length-1:0] h_reg_q, h_reg_d;
  logic              m_valid_q, m_valid_d;
  logic [length-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;

  logic              accept;
  logic              col_end;
  logic              row_end;
  phase_e            phase;
  logic [SUM_W-1:0]  hsum;
  logic [SUM_W-1:0]  lb_rdata;
  logic [AW-1:0]     lb_addr;
  logic              lb_we;
  logic [TOT_W-1:0]  total;
  logic [TOT_W-1:0]  rounded;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign col_end = (col_q == CW'(WIDTH - 1));
  assign row_end = (row_q == RW'(HEIGHT - 1));
  assign phase   = phase_e'({row_q[0], col_q[0]});

  assign hsum    = SUM_W'(h_reg_q) + SUM_W'(s_data);
  assign lb_addr = AW'(col_q >> 1);
  assign lb_we   = accept && (phase == PH_EVEN_ROW_ODD_COL);
  assign total   = TOT_W'(lb_rdata) + TOT_W'(hsum);

`ifdef DOWNSAMPLE_ROUND_EN
  // Max total is 2^(length+2)-4, so +2 still fits TOT_W bits.
  assign rounded = total + TOT_W'(2);
`else
  assign rounded = total;
`endif

  ds_line_buffer #(
    .DATA_W (SUM_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hsum),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    h_reg_d   = h_reg_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;

    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
      if (!col_q[0]) h_reg_d = s_data;
    end

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    // A new result overrides the handshake clear, so back-to-back outputs have no bubble.
    if (accept && (phase == PH_ODD_ROW_ODD_COL)) begin
      m_valid_d = 1'b1;
      m_data_d  = length'(rounded >> 2);
      m_last_d  = row_end && col_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      h_reg_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      h_reg_q   <= h_reg_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule
